btn_digit_entry: RTL and testbench
==================================

# btn_digit_entry

Front-panel input stage feeding the RV32I core's calculator program. It conditions the five raw push-buttons (sync, debounce, rising-edge detect), maintains an editable NUM_DIGITS-digit BCD number with a cursor, and on the center button converts the number to binary over multiple cycles. It then hands the binary operand to the core with a one-cycle `calc_start` pulse and holds off editing until the core reports `calc_done`.

## Interface
- `NUM_DIGITS`, 8: BCD digits held; 1..9, so the value always fits 32 bits.
- `DEBOUNCE_CYCLES`, 4: consecutive stable synchronized samples required to accept a level change; board builds use 1_000_000.
- `clk`  in  1  system clock; the single clock domain.
- `rst_n`  in  1  reset, synchronous, active-low.
- `btn_center_in`, `btn_up_in`, `btn_down_in`, `btn_left_in`, `btn_right_in`  in  1 each  raw asynchronous buttons, active-high.
- `calc_done`  in  1  one-cycle pulse from the core: result ready.
- `digits_bcd`  out  4*NUM_DIGITS  entered digits; digit i occupies bits [4i+3:4i], and digit 0 is least significant.
- `cursor`  out  $clog2(NUM_DIGITS) (min 1)  index of the digit being edited.
- `operand`  out  32  binary value of the last converted entry; held until the next conversion completes.
- `calc_start`  out  1  one-cycle pulse; `operand` is valid in the same cycle.
- `busy`  out  1  high in CONVERT and BUSY states.

## Operation
- Per button: 2-FF synchronizer, then debounce counter. The debounced level toggles once the synchronized value differs from it for DEBOUNCE_CYCLES consecutive cycles; the counter clears on any sample equal to the debounced level. A rising debounced edge produces a registered one-cycle event.
- States: EDIT, CONVERT, BUSY.
- EDIT, events handled at most one per cycle, in priority order center > up > down > left > right. Lower-priority events arriving in the same cycle are dropped.
  - up: digit[cursor] +1, wraps 9 -> 0.
  - down: digit[cursor] -1, wraps 0 -> 9.
  - left: cursor +1, wraps NUM_DIGITS-1 -> 0.
  - right: cursor -1, wraps 0 -> NUM_DIGITS-1.
  - center: clear the accumulator, set the step index to NUM_DIGITS-1, go to CONVERT.
- CONVERT: one digit per cycle, most significant first: acc <= (acc<<3) + (acc<<1) + digit[idx], using 32-bit arithmetic that cannot overflow. After the digit-0 step, the next cycle loads `operand` <= acc, pulses `calc_start`, and goes to BUSY.
- BUSY: wait for `calc_done`, then return to EDIT on the next cycle.
- Events arriving in CONVERT or BUSY are discarded, not queued.
- `calc_done` arriving in EDIT or CONVERT is ignored.
- Digits and cursor are never modified outside EDIT.

## Timing
- Reset (rst_n low at a clk edge) gives:
  - all digits 0, cursor 0, operand 0, calc_start 0, busy 0;
  - state EDIT, synchronizers and debounced levels 0, counters 0.
- Reset mid-conversion or mid-BUSY aborts without emitting `calc_start`.
- Button latency: a raw rise sampled at edge k propagates as follows.
  - Synchronized value high at k+2.
  - Debounced level high at k+2+DEBOUNCE_CYCLES.
  - Event pulse at k+3+DEBOUNCE_CYCLES.
  - Digit/cursor update visible one cycle after the event.
- A press shorter than DEBOUNCE_CYCLES synchronized cycles produces no event. A held button produces exactly one event.
- Center event in cycle c gives:
  - `busy` high from c+1;
  - CONVERT occupying c+1 .. c+NUM_DIGITS;
  - `calc_start` and the new `operand` at c+NUM_DIGITS+1.
- `calc_done` in cycle d (BUSY) returns the block to EDIT at d+1 with `busy` low. A `calc_done` in the same cycle as `calc_start` is ignored.

## Structure
- Shared package/header holds:
  - state encoding `ST_EDIT`/`ST_CONVERT`/`ST_BUSY`;
  - button index constants `BTN_CENTER..BTN_RIGHT`;
  - `BCD_MAX = 4'd9`.
- Sub-module `btn_conditioner` (synchronizer + debounce + edge detect, parameter DEBOUNCE_CYCLES), instantiated five times.
- FSM, digit/cursor registers and converter stay in the top module.

## Test plan
- Reset and sequence (DEBOUNCE_CYCLES=4, NUM_DIGITS=8, presses 10 cycles high / 10 low):
  - up x4, left, up x2, left x2, up x6;
  - required: `digits_bcd`=32'h0000_6024, cursor=3;
  - then center: `calc_start` pulses exactly 9 cycles after the center event, with `operand`=6024.
- Wrap-around:
  - down on 0 gives 9; up on 9 gives 0;
  - right at cursor 0 gives cursor 7; left at cursor 7 gives cursor 0.
- Debounce:
  - a 3-cycle glitch on btn_up_in leaves digits unchanged;
  - a 50-cycle hold gives exactly one increment.
- Hold-off:
  - up/left/center pressed while `busy` cause no change and no second `calc_start`;
  - `calc_done` returns the block to EDIT, and a later up press edits normally.
- Simultaneous and abort:
  - center and up events in the same cycle give conversion only, with the digit unchanged;
  - rst_n low during CONVERT gives no `calc_start` and all outputs at their reset values.
- Max value: digits all 9 converts to `operand`=99_999_999 (32'h05F5_E0FF).

Source files
------------

// File: rtl/btn_digit_entry_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// btn_digit_entry_pkg : shared states, button indices and BCD limit. rev 1.0
// ---------------------------------------------------------------------------
package btn_digit_entry_pkg;

    typedef enum logic [1:0] {
        ST_EDIT    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_BUSY    = 2'd2
    } state_t;

    localparam int BTN_CENTER = 0;
    localparam int BTN_UP     = 1;
    localparam int BTN_DOWN   = 2;
    localparam int BTN_LEFT   = 3;
    localparam int BTN_RIGHT  = 4;
    localparam int NUM_BTNS   = 5;

    localparam logic [3:0] BCD_MAX = 4'd9;

endpackage
`default_nettype wire

// File: rtl/btn_digit_entry_conditioner.sv
`default_nettype none
// ---------------------------------------------------------------------------
// btn_conditioner : 2-FF sync, debounce, registered rising-edge event. rev 1.0
// ---------------------------------------------------------------------------
module btn_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_meta;
    logic             sync_out;
    logic             level;
    logic             level_d;
    logic             press_q;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_meta <= 1'b0;
            sync_out  <= 1'b0;
            level     <= 1'b0;
            level_d   <= 1'b0;
            press_q   <= 1'b0;
            cnt       <= '0;
        end else begin
            sync_meta <= btn_raw;
            sync_out  <= sync_meta;
            level_d   <= level;
            press_q   <= level & ~level_d;
            // Any sample agreeing with the accepted level restarts the count.
            if (sync_out == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt   <= '0;
                level <= ~level;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign press = press_q;

endmodule
`default_nettype wire

// File: rtl/btn_digit_entry.sv
`default_nettype none
// ---------------------------------------------------------------------------
// btn_digit_entry : button-driven BCD entry with serial BCD-to-binary handoff.
// rev 1.0
// ---------------------------------------------------------------------------
module btn_digit_entry
    import btn_digit_entry_pkg::*;
#(
    parameter int NUM_DIGITS      = 8,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                                                clk,
    input  logic                                                rst_n,
    input  logic                                                btn_center_in,
    input  logic                                                btn_up_in,
    input  logic                                                btn_down_in,
    input  logic                                                btn_left_in,
    input  logic                                                btn_right_in,
    input  logic                                                calc_done,
    output logic [4*NUM_DIGITS-1:0]                             digits_bcd,
    output logic [((NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1)-1:0] cursor,
    output logic [31:0]                                         operand,
    output logic                                                calc_start,
    output logic                                                busy
);

    localparam int CUR_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CUR_W-1:0] CUR_LAST = CUR_W'(NUM_DIGITS - 1);

    logic [NUM_BTNS-1:0] btn_raw;
    logic [NUM_BTNS-1:0] btn_evt;

    assign btn_raw[BTN_CENTER] = btn_center_in;
    assign btn_raw[BTN_UP]     = btn_up_in;
    assign btn_raw[BTN_DOWN]   = btn_down_in;
    assign btn_raw[BTN_LEFT]   = btn_left_in;
    assign btn_raw[BTN_RIGHT]  = btn_right_in;

    for (genvar g = 0; g < NUM_BTNS; g++) begin : g_btn
        btn_conditioner #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_cond (
            .clk     (clk),
            .rst_n   (rst_n),
            .btn_raw (btn_raw[g]),
            .press   (btn_evt[g])
        );
    end

    state_t                      state;
    state_t                      state_next;
    logic [NUM_DIGITS-1:0][3:0]  digits;
    logic [CUR_W-1:0]            cur;
    logic [CUR_W-1:0]            idx;
    logic [31:0]                 acc;
    logic [31:0]                 acc_next;
    logic [31:0]                 operand_q;
    logic                        start_q;
    logic [3:0]                  cur_digit;

    assign cur_digit = digits[cur];
    // acc*10 + digit; the largest 9-digit value still fits in 32 bits.
    assign acc_next  = (acc << 3) + (acc << 1) + {28'd0, digits[idx]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_EDIT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_EDIT: begin
                if (btn_evt[BTN_CENTER]) begin
                    state_next = ST_CONVERT;
                end
            end
            ST_CONVERT: begin
                if (idx == '0) begin
                    state_next = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // A done coinciding with our own start pulse is stale.
                if (calc_done && !start_q) begin
                    state_next = ST_EDIT;
                end
            end
            default: state_next = ST_EDIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            digits    <= '0;
            cur       <= '0;
            idx       <= '0;
            acc       <= '0;
            operand_q <= '0;
            start_q   <= 1'b0;
        end else begin
            start_q <= 1'b0;
            case (state)
                ST_EDIT: begin
                    if (btn_evt[BTN_CENTER]) begin
                        acc <= '0;
                        idx <= CUR_LAST;
                    end else if (btn_evt[BTN_UP]) begin
                        digits[cur] <= (cur_digit == BCD_MAX) ? 4'd0 : cur_digit + 4'd1;
                    end else if (btn_evt[BTN_DOWN]) begin
                        digits[cur] <= (cur_digit == 4'd0) ? BCD_MAX : cur_digit - 4'd1;
                    end else if (btn_evt[BTN_LEFT]) begin
                        cur <= (cur == CUR_LAST) ? '0 : cur + 1'b1;
                    end else if (btn_evt[BTN_RIGHT]) begin
                        cur <= (cur == '0) ? CUR_LAST : cur - 1'b1;
                    end
                end
                ST_CONVERT: begin
                    acc <= acc_next;
                    idx <= idx - 1'b1;
                    if (idx == '0) begin
                        operand_q <= acc_next;
                        start_q   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign digits_bcd = digits;
    assign cursor     = cur;
    assign operand    = operand_q;
    assign calc_start = start_q;
    assign busy       = (state != ST_EDIT);

endmodule
`default_nettype wire

// File: tb/tb_btn_digit_entry.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_btn_digit_entry : table-driven edits plus scoreboarded conversions. rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_btn_digit_entry;
    import btn_digit_entry_pkg::*;

    localparam int ND  = 8;
    localparam int DB  = 4;
    // Drive negedge to the negedge where calc_start is seen.
    localparam int LAT = 1 + 3 + DB + ND;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [NUM_BTNS-1:0] btn = '0;
    logic                calc_done = 1'b0;
    logic [4*ND-1:0]     digits_bcd;
    logic [2:0]          cursor;
    logic [31:0]         operand;
    logic                calc_start;
    logic                busy;

    btn_digit_entry #(
        .NUM_DIGITS      (ND),
        .DEBOUNCE_CYCLES (DB)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .btn_center_in (btn[BTN_CENTER]),
        .btn_up_in     (btn[BTN_UP]),
        .btn_down_in   (btn[BTN_DOWN]),
        .btn_left_in   (btn[BTN_LEFT]),
        .btn_right_in  (btn[BTN_RIGHT]),
        .calc_done     (calc_done),
        .digits_bcd    (digits_bcd),
        .cursor        (cursor),
        .operand       (operand),
        .calc_start    (calc_start),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          b;
        int          hold;
        logic [31:0] exp_digits;
        logic [2:0]  exp_cursor;
    } vec_t;

    typedef struct {
        logic [31:0] op;
        int          at;
    } sb_t;

    vec_t tbl[$];
    sb_t  sb[$];
    int   checks = 0;
    int   passes = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic add(input int b, input int hold, input logic [31:0] d, input logic [2:0] c);
        vec_t v;
        v.b = b; v.hold = hold; v.exp_digits = d; v.exp_cursor = c;
        tbl.push_back(v);
    endtask

    task automatic press(input int b, input int hold);
        @(negedge clk);
        btn[b] = 1'b1;
        repeat (hold) @(negedge clk);
        btn[b] = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic apply(input int i);
        press(tbl[i].b, tbl[i].hold);
        check($sformatf("vec%0d digits", i), digits_bcd, tbl[i].exp_digits);
        check($sformatf("vec%0d cursor", i), {29'd0, cursor}, {29'd0, tbl[i].exp_cursor});
    endtask

    task automatic expect_start(input logic [31:0] op);
        sb_t e;
        e.op = op; e.at = cyc + LAT;
        sb.push_back(e);
    endtask

    task automatic center_press(input logic [31:0] op);
        @(negedge clk);
        expect_start(op);
        btn[BTN_CENTER] = 1'b1;
        repeat (10) @(negedge clk);
        btn[BTN_CENTER] = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic done_pulse(input string name);
        @(negedge clk);
        calc_done = 1'b1;
        @(negedge clk);
        calc_done = 1'b0;
        check(name, {31'd0, busy}, 32'd0);
    endtask

    // Scoreboard: every calc_start must match the oldest expected conversion.
    always @(negedge clk) begin
        sb_t e;
        if (calc_start === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected calc_start", {31'd0, calc_start}, 32'd0);
            end else begin
                e = sb.pop_front();
                check("operand", operand, e.op);
                check("calc_start cycle", cyc, e.at);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int found;

        add(BTN_UP,    10, 32'h0000_0001, 3'd0);
        add(BTN_UP,    10, 32'h0000_0002, 3'd0);
        add(BTN_UP,    10, 32'h0000_0003, 3'd0);
        add(BTN_UP,    10, 32'h0000_0004, 3'd0);
        add(BTN_LEFT,  10, 32'h0000_0004, 3'd1);
        add(BTN_UP,    10, 32'h0000_0014, 3'd1);
        add(BTN_UP,    10, 32'h0000_0024, 3'd1);
        add(BTN_LEFT,  10, 32'h0000_0024, 3'd2);
        add(BTN_LEFT,  10, 32'h0000_0024, 3'd3);
        add(BTN_UP,    10, 32'h0000_1024, 3'd3);
        add(BTN_UP,    10, 32'h0000_2024, 3'd3);
        add(BTN_UP,    10, 32'h0000_3024, 3'd3);
        add(BTN_UP,    10, 32'h0000_4024, 3'd3);
        add(BTN_UP,    10, 32'h0000_5024, 3'd3);
        add(BTN_UP,    10, 32'h0000_6024, 3'd3);
        add(BTN_UP,     3, 32'h0000_6024, 3'd3);
        add(BTN_UP,    50, 32'h0000_7024, 3'd3);
        add(BTN_RIGHT, 10, 32'h0000_7024, 3'd2);
        add(BTN_RIGHT, 10, 32'h0000_7024, 3'd1);
        add(BTN_RIGHT, 10, 32'h0000_7024, 3'd0);
        add(BTN_RIGHT, 10, 32'h0000_7024, 3'd7);
        add(BTN_DOWN,  10, 32'h9000_7024, 3'd7);
        add(BTN_UP,    10, 32'h0000_7024, 3'd7);
        add(BTN_LEFT,  10, 32'h0000_7024, 3'd0);

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset digits", digits_bcd, 32'd0);
        check("reset cursor", {29'd0, cursor}, 32'd0);
        check("reset operand", operand, 32'd0);
        check("reset calc_start", {31'd0, calc_start}, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) apply(i);

        center_press(32'd6024);
        check("busy after convert", {31'd0, busy}, 32'd1);
        press(BTN_UP, 10);
        press(BTN_LEFT, 10);
        press(BTN_CENTER, 10);
        check("holdoff digits", digits_bcd, 32'h0000_6024);
        check("holdoff cursor", {29'd0, cursor}, 32'd3);
        check("holdoff busy", {31'd0, busy}, 32'd1);
        done_pulse("busy after done");

        for (int i = 15; i < 24; i++) apply(i);

        // calc_done in the very cycle of calc_start must not end BUSY.
        @(negedge clk);
        expect_start(32'd7024);
        btn[BTN_CENTER] = 1'b1;
        found = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            @(negedge clk);
            if (calc_start === 1'b1) found = 1;
        end
        check("calc_start seen", found, 32'd1);
        calc_done = 1'b1;
        @(negedge clk);
        calc_done = 1'b0;
        check("busy with coincident done", {31'd0, busy}, 32'd1);
        btn[BTN_CENTER] = 1'b0;
        repeat (20) @(negedge clk);
        done_pulse("busy after late done");

        // Center and up in the same cycle: conversion only.
        @(negedge clk);
        expect_start(32'd7024);
        btn[BTN_CENTER] = 1'b1;
        btn[BTN_UP] = 1'b1;
        repeat (10) @(negedge clk);
        btn[BTN_CENTER] = 1'b0;
        btn[BTN_UP] = 1'b0;
        repeat (10) @(negedge clk);
        check("simultaneous digits", digits_bcd, 32'h0000_7024);
        done_pulse("busy after simultaneous");

        // Reset during CONVERT aborts with no calc_start.
        @(negedge clk);
        btn[BTN_CENTER] = 1'b1;
        found = 0;
        for (int i = 0; i < 30 && found == 0; i++) begin
            @(negedge clk);
            if (busy === 1'b1) found = 1;
        end
        check("busy for abort", found, 32'd1);
        repeat (3) @(negedge clk);
        btn[BTN_CENTER] = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("abort digits", digits_bcd, 32'd0);
        check("abort cursor", {29'd0, cursor}, 32'd0);
        check("abort operand", operand, 32'd0);
        check("abort calc_start", {31'd0, calc_start}, 32'd0);
        check("abort busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        check("abort pending", sb.size(), 32'd0);

        for (int i = 0; i < ND; i++) begin
            press(BTN_DOWN, 10);
            press(BTN_LEFT, 10);
        end
        check("max digits", digits_bcd, 32'h9999_9999);
        check("max cursor", {29'd0, cursor}, 32'd0);
        center_press(32'd99_999_999);
        done_pulse("busy after max");
        check("final pending", sb.size(), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
